// File: rtl/multicore_dmem_arbiter_if.sv
// Core-array and data-memory signal bundle for the shared data-memory arbiter.
// The arbiter uses the slave modport; the core/memory side uses master.
interface multicore_dmem_arbiter_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CNT_W     = 16
);
    logic                        START;
    logic [NUM_CORES-1:0]        core_rd_req;
    logic [NUM_CORES-1:0]        core_wr_req;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES*DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]        core_end;
    logic [NUM_CORES-1:0]        core_gnt;
    logic [NUM_CORES-1:0]        core_rvalid;
    logic [DATA_W-1:0]           core_rdata;
    logic                        mem_read;
    logic                        mem_write;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        END;
    logic                        conflict_err;
    logic [CNT_W-1:0]            contention_count;

    modport slave (
        input  START, core_rd_req, core_wr_req, core_addr, core_wdata, core_end, mem_rdata,
        output core_gnt, core_rvalid, core_rdata, mem_read, mem_write, mem_addr, mem_wdata,
               END, conflict_err, contention_count
    );

    modport master (
        output START, core_rd_req, core_wr_req, core_addr, core_wdata, core_end, mem_rdata,
        input  core_gnt, core_rvalid, core_rdata, mem_read, mem_write, mem_addr, mem_wdata,
               END, conflict_err, contention_count
    );
endinterface

// File: rtl/multicore_dmem_arbiter.sv
// Round-robin arbiter giving NUM_CORES cores access to one synchronous data memory,
// with one-cycle read return, sticky rd/wr conflict flag and a contention counter.
module multicore_dmem_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CNT_W     = 16
) (
    input logic                    clk,
    input logic                    RESET,
    multicore_dmem_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_CORES-1:0] end_q, end_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [PTR_W-1:0]     rd_idx_q, rd_idx_d;
    logic                 conflict_q, conflict_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_CORES-1:0] pending;
    logic [NUM_CORES-1:0] gnt;
    logic [NUM_CORES-1:0] rvalid;
    logic                 gnt_vld;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 sel_rd, sel_wr;
    logic                 multi_pending;

    // Search upward from the pointer; the first pending core wins.
    always_comb begin : arbitrate
        int unsigned cand;
        cand    = 0;
        pending = '0;
        if (state_q == RUN)
            pending = (bus.core_rd_req | bus.core_wr_req) & ~end_q;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            cand = (32'(ptr_q) + k) % NUM_CORES;
            if (!gnt_vld && pending[PTR_W'(cand)]) begin
                gnt_vld = 1'b1;
                gnt_idx = PTR_W'(cand);
            end
        end
        gnt = '0;
        if (gnt_vld)
            gnt[gnt_idx] = 1'b1;
        sel_rd        = gnt_vld & bus.core_rd_req[gnt_idx];
        sel_wr        = gnt_vld & bus.core_wr_req[gnt_idx];
        multi_pending = |(pending & (pending - NUM_CORES'(1)));
    end

    always_comb begin
        rvalid = '0;
        if (rd_vld_q)
            rvalid[rd_idx_q] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        end_d      = end_q;
        cnt_d      = cnt_q;
        rd_vld_d   = sel_rd & ~sel_wr;
        rd_idx_d   = gnt_idx;
        conflict_d = conflict_q | (sel_rd & sel_wr);
        case (state_q)
            IDLE: begin
                if (bus.START)
                    state_d = RUN;
            end
            RUN: begin
                // Leave RUN on the edge that sets the last end latch, so END rises the following cycle.
                end_d = end_q | bus.core_end;
                if (&end_d)
                    state_d = DONE;
                if (gnt_vld)
                    ptr_d = (gnt_idx == PTR_W'(NUM_CORES - 1)) ? '0 : gnt_idx + PTR_W'(1);
                if (multi_pending && (cnt_q != '1))
                    cnt_d = cnt_q + CNT_W'(1);
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            end_q      <= '0;
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            end_q      <= end_d;
            rd_vld_q   <= rd_vld_d;
            rd_idx_q   <= rd_idx_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.core_gnt         = gnt;
    assign bus.core_rvalid      = rvalid;
    assign bus.core_rdata       = rd_vld_q ? bus.mem_rdata : '0;
    assign bus.mem_write        = sel_wr;
    assign bus.mem_read         = sel_rd & ~sel_wr;
    assign bus.mem_addr         = gnt_vld ? bus.core_addr[32'(gnt_idx) * ADDR_W +: ADDR_W] : '0;
    assign bus.mem_wdata        = gnt_vld ? bus.core_wdata[32'(gnt_idx) * DATA_W +: DATA_W] : '0;
    assign bus.END              = (state_q == DONE);
    assign bus.conflict_err     = conflict_q;
    assign bus.contention_count = cnt_q;
endmodule

// File: doc/multicore_dmem_arbiter.md
Name: multicore_dmem_arbiter

Overview:
- Shared data-memory front end for the multicore generation of the processor top level.
- Connects NUM_CORES cores to one synchronous data_memory port.
- Arbitrates between per-core read/write requests round-robin, returns read data with a one-cycle latency, and combines the per-core end flags into a single END.
- Sits between the core array and data_memory; instruction fetch is outside this block.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..16).
- ADDR_W, 16, data-memory address width.
- DATA_W, 16, data word width.
- CNT_W, 16, width of the contention counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  run trigger, sampled in IDLE.
- core_rd_req  input  NUM_CORES  per-core read request, held until granted.
- core_wr_req  input  NUM_CORES  per-core write request, held until granted.
- core_addr  input  NUM_CORES*ADDR_W  packed addresses; core i at [i*ADDR_W +: ADDR_W].
- core_wdata  input  NUM_CORES*DATA_W  packed write data, same packing.
- core_end  input  NUM_CORES  per-core end_i flag.
- core_gnt  output  NUM_CORES  one-hot grant; access is performed in this cycle.
- core_rvalid  output  NUM_CORES  one-hot pulse one cycle after a read grant.
- core_rdata  output  DATA_W  read data broadcast to all cores; qualified by core_rvalid.
- mem_read  output  1  to data_memory read.
- mem_write  output  1  to data_memory write.
- mem_addr  output  ADDR_W  to data_memory address.
- mem_wdata  output  DATA_W  to data_memory data_in.
- mem_rdata  input  DATA_W  from data_memory data_out; valid one cycle after mem_read.
- END  output  1  all cores finished.
- conflict_err  output  1  sticky: a core asserted rd and wr together.
- contention_count  output  CNT_W  cycles with two or more pending requesters.

Behaviour:
- Reset (asynchronous, any state, mid-transaction included):
  - state goes to IDLE and the round-robin pointer goes to 0.
  - All end latches, conflict_err, contention_count and the rvalid pipeline clear.
  - All outputs read 0.
  - An outstanding read is dropped and no rvalid is issued for it.
- States:
  - IDLE -> RUN when START=1 at a rising edge.
  - RUN -> DONE the cycle after every end latch is set.
  - DONE holds until RESET. START is ignored in RUN and DONE.
- Grants are issued only in RUN. In IDLE and DONE, core_gnt, mem_read and mem_write are 0.
- Arbitration (combinational within the cycle):
  - A core is pending when rd_req or wr_req is set and its end latch is clear.
  - Grant goes to the first pending core found searching upward from the pointer, modulo NUM_CORES.
  - At most one grant per cycle.
- Pointer update at the edge: if core i was granted, pointer becomes (i+1) mod NUM_CORES. With no grant, the pointer holds.
- Granted access drives the memory in the same cycle:
  - mem_addr and mem_wdata come from the granted core.
  - mem_write = wr_req of the granted core.
  - mem_read = rd_req of the granted core, forced to 0 if wr_req is also set.
  - With no grant, mem_addr and mem_wdata are 0.
- Conflict: rd_req and wr_req set together on a granted core is performed as a write only, and conflict_err is set and held sticky.
- Read return: granted read in cycle k gives core_rvalid[i]=1 in cycle k+1, with core_rdata = mem_rdata in that cycle. core_rdata is 0 whenever no rvalid is asserted.
- Back-to-back reads to different cores are allowed: one rvalid per cycle, in grant order.
- A core must deassert or change its request in the cycle after core_gnt. A request still held is treated as a new request.
- End latches: core_end[i]=1 in RUN sets latch i, and it stays set (later deassertion is ignored). A core with its latch set is never granted.
- END = 1 in DONE only, and stays 1 until RESET.
- contention_count increments in RUN on each cycle with two or more pending cores, and saturates at all-ones.

Test Plan:
- NUM_CORES=4. Reset, then START; cores 0-3 all hold rd_req at addresses 0x10-0x13 -> grants in order 0,1,2,3 on consecutive cycles, each rvalid one cycle later with the matching memory word; contention_count=3.
- Pointer at 2; cores 1 and 3 request writes of 0xAAAA/0xBBBB to 0x20/0x21 -> core 3 granted first, then core 1; memory reads back 0xBBBB at 0x21 and 0xAAAA at 0x20.
- Core 2 asserts rd_req and wr_req together with data 0x1234 to 0x30 -> write performed, no rvalid, conflict_err=1 and sticky.
- Cores end in order 3,0,2,1 with core 3 still requesting -> core 3 is never granted after its end; END=1 one cycle after core 1's end; further START and requests produce no grants.
- Assert RESET in the cycle after a read grant -> no rvalid, all outputs 0, pointer 0; after the next START, core 0 wins a 4-way tie.
- START held low with requests pending -> no grants and mem_read=mem_write=0 indefinitely.
